seq_mult_32: RTL and testbench

SEQ_MULT_32 -- requirements
Module: seq_mult_32

---
 rtl/seq_mult_32.sv | 138 +++++++++++++
 tb/tb_seq_mult_32.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_mult_32.sv
//==============================================================================
// Module      : seq_mult_32
// Description : 32x32 signed sequential multiplier. Radix-2 Booth, one step
//               per clock, all add/subtract through one ripple-carry unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef DATA_INDEX_LIMIT
`define DATA_INDEX_LIMIT 31
`endif

module RC_ADD_SUB_32 (
  input  logic [`DATA_INDEX_LIMIT:0] A,
  input  logic [`DATA_INDEX_LIMIT:0] B,
  input  logic                       SnA,
  output logic [`DATA_INDEX_LIMIT:0] Y,
  output logic                       CO
);
  localparam int c_width = `DATA_INDEX_LIMIT + 1;

  // Subtraction is A + ~B + 1: invert B and feed SnA in as the carry
  logic [c_width:0]   w_carry;
  logic [c_width-1:0] w_b;

  assign w_carry[0] = SnA;
  assign w_b        = B ^ {c_width{SnA}};

  genvar i;
  generate
    for (i = 0; i < c_width; i++) begin : g_fa
      assign Y[i]         = A[i] ^ w_b[i] ^ w_carry[i];
      assign w_carry[i+1] = (A[i] & w_b[i]) | (w_carry[i] & (A[i] ^ w_b[i]));
    end
  endgenerate

  assign CO = w_carry[c_width];
endmodule

module seq_mult_32 (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [`DATA_INDEX_LIMIT:0] A,
  input  logic [`DATA_INDEX_LIMIT:0] B,
  output logic [`DATA_INDEX_LIMIT:0] HI,
  output logic [`DATA_INDEX_LIMIT:0] LO,
  output logic                       BUSY,
  output logic                       DONE
);
  localparam int c_width = `DATA_INDEX_LIMIT + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_width-1:0] r_m;
  logic [c_width-1:0] r_acc;
  logic [c_width-1:0] r_q;
  logic               r_q_1;
  logic [5:0]         r_cnt;

  logic [1:0]         w_sel;
  logic               w_sna;
  logic               w_do_op;
  logic [c_width-1:0] w_sum;
  logic [c_width-1:0] w_b_eff;
  logic [c_width-1:0] w_r;
  logic               w_v;
  logic               w_s;
  logic               w_co_unused;

  assign w_sel   = {r_q[0], r_q_1};
  assign w_sna   = (w_sel == 2'b10);
  assign w_do_op = w_sel[1] ^ w_sel[0];

  RC_ADD_SUB_32 u_addsub (
    .A   (r_acc),
    .B   (r_m),
    .SnA (w_sna),
    .Y   (w_sum),
    .CO  (w_co_unused)
  );

  // Sign of the true 33-bit result: the 32-bit sign corrected by overflow,
  // so that ACC - 0x80000000 shifts in the right sign bit.
  assign w_b_eff = r_m ^ {c_width{w_sna}};
  assign w_r     = w_do_op ? w_sum : r_acc;
  assign w_v     = w_do_op & (r_acc[c_width-1] == w_b_eff[c_width-1])
                           & (w_sum[c_width-1] != r_acc[c_width-1]);
  assign w_s     = w_r[c_width-1] ^ w_v;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 6'd31) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && START) begin
        r_m   <= A;
        r_q   <= B;
        r_acc <= '0;
        r_q_1 <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= {w_s, w_r[c_width-1:1]};
        r_q   <= {w_r[0], r_q[c_width-1:1]};
        r_q_1 <= r_q[0];
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  assign HI   = r_acc;
  assign LO   = r_q;
  assign BUSY = (r_state != S_IDLE);
  assign DONE = (r_state == S_DONE);
endmodule

`default_nettype wire

// File: tb/tb_seq_mult_32.sv
//==============================================================================
// Module      : tb_seq_mult_32
// Description : Directed self-checking bench for seq_mult_32.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_mult_32;
  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  seq_mult_32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one multiply, expect DONE in the cycle after the 32nd RUN edge
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
    int n;
    A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0;
    chk({tag, "_busy_run"}, {63'd0, BUSY}, 64'd1);
    n = 0;
    while (!DONE && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_product"}, {HI, LO}, exp);
    chk({tag, "_busy_done"}, {63'd0, BUSY}, 64'd1);
    A = ~a; B = ~b;
    tick();
    chk({tag, "_done_pulse"}, {62'd0, DONE, BUSY}, 64'd0);
    chk({tag, "_hold"}, {HI, LO}, exp);
  endtask

  initial begin
    int pulses;
    logic [63:0] prod;

    RST = 1'b0; START = 1'b0; A = 32'd0; B = 32'd0;
    tick();
    tick();
    chk("reset_state", {HI, LO}, 64'd0);
    chk("reset_flags", {62'd0, BUSY, DONE}, 64'd0);
    RST = 1'b1;

    // Idle with START low: nothing moves
    A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    tick();
    tick();
    chk("idle_hold", {HI, LO, 1'b0}, {64'd0, 1'b0});
    chk("idle_busy", {63'd0, BUSY}, 64'd0);

    do_mult(32'd7,          32'd6,          64'h00000000_0000002A, "p7x6");
    do_mult(32'hFFFF_FFFD,  32'd5,          64'hFFFFFFFF_FFFFFFF1, "m3x5");
    do_mult(32'h8000_0000,  32'h8000_0000,  64'h40000000_00000000, "minxmin");
    do_mult(32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFFFFFF_00000001, "maxxmax");
    do_mult(32'd0,          32'hFFFF_FFFF,  64'd0,                 "zeroxm1");

    // START and operand changes during RUN are ignored
    A = 32'd3; B = 32'd4; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    START = 1'b1; A = 32'd9; B = 32'd9;
    tick();
    START = 1'b0;
    pulses = 0;
    prod = '1;
    for (int i = 0; i < 45; i++) begin
      if (DONE) begin
        pulses++;
        prod = {HI, LO};
      end
      tick();
    end
    chk("ignore_start_pulses", 64'(pulses), 64'd1);
    chk("ignore_start_product", prod, 64'd12);
    chk("ignore_start_idle", {63'd0, BUSY}, 64'd0);

    // Reset mid-RUN abandons the operation
    A = 32'd100; B = 32'd100; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (9) tick();
    RST = 1'b0; START = 1'b1;
    tick();
    RST = 1'b1; START = 1'b0;
    chk("midrun_reset_data", {HI, LO}, 64'd0);
    chk("midrun_reset_flags", {62'd0, BUSY, DONE}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE || BUSY) pulses++;
      tick();
    end
    chk("midrun_no_done", 64'(pulses), 64'd0);

    do_mult(32'd2, 32'hFFFF_FFFE, 64'hFFFFFFFF_FFFFFFFC, "p2xm2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
